// File: rtl/pc_unit_pkg.sv
// Shared constants, next-PC source encoding and helpers for the fetch-stage program counter.
package pc_unit_pkg;

  localparam logic [31:0] PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_DEFAULT  = 32'h0000_4180;
  localparam int unsigned STEP_DEFAULT = 32'd4;
  localparam logic [15:0] SEQ_MAX      = 16'hFFFF;

  typedef enum logic [2:0] {
    SRC_HOLD = 3'd0,
    SRC_EXC  = 3'd1,
    SRC_ERET = 3'd2,
    SRC_BR   = 3'd3,
    SRC_PEND = 3'd4,
    SRC_SEQ  = 3'd5
  } pc_src_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == SEQ_MAX) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/pc_unit_redirect_hold.sv
// One-entry pending branch register: remembers a branch target that arrived while fetch was stalled.
module pc_redirect_hold
  #(
    parameter int WIDTH = 32
  )
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic             consume,
    input  logic             flush,
    input  logic [WIDTH-1:0] capture_target,
    output logic             valid,
    output logic [WIDTH-1:0] target
  );

  // Clearing beats capture; a later capture simply overwrites the held target.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (flush || consume) begin
      valid  <= 1'b0;
    end else if (capture) begin
      valid  <= 1'b1;
      target <= capture_target;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect arbitration and stall-safe branch capture.
// Exception/eret vectoring and the misalignment flag are enabled by defining PC_EXC_EN.
module pc_unit
  import pc_unit_pkg::*;
  #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(PC_DEFAULT),
    parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(EXC_DEFAULT),
    parameter int unsigned       STEP      = STEP_DEFAULT
  )
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redirect_pending,
    output logic             adel,
    output logic [15:0]      seq_count
  );

  logic             exc_live;
  logic             eret_live;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             capture;
  logic             consume;
  logic             flush;
  pc_src_e          src;

`ifdef PC_EXC_EN
  assign exc_live  = exc_req;
  assign eret_live = eret_req;
  assign adel      = (pc[1:0] != 2'b00);
`else
  logic unused_exc_inputs;
  assign unused_exc_inputs = ^{exc_req, eret_req, epc};
  assign exc_live  = 1'b0;
  assign eret_live = 1'b0;
  assign adel      = 1'b0;
`endif

  assign pc_plus          = pc + WIDTH'(STEP);
  assign redirect_pending = pend_valid;

  // Next-PC source selection in priority order (reset is handled in the register).
  always_comb begin
    src = SRC_HOLD;
    if (exc_live) begin
      src = SRC_EXC;
    end else if (eret_live) begin
      src = SRC_ERET;
    end else if (en && br_valid) begin
      src = SRC_BR;
    end else if (en && pend_valid) begin
      src = SRC_PEND;
    end else if (en) begin
      src = SRC_SEQ;
    end else begin
      src = SRC_HOLD;
    end
  end

  // A live branch or CP0 redirect is newer than anything held, so it flushes the entry.
  assign capture = !en && br_valid && !exc_live && !eret_live;
  assign consume = (src == SRC_PEND);
  assign flush   = exc_live || eret_live || (en && br_valid);

  pc_redirect_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk            (clk),
    .reset          (reset),
    .capture        (capture),
    .consume        (consume),
    .flush          (flush),
    .capture_target (br_target),
    .valid          (pend_valid),
    .target         (pend_target)
  );

  // PC and sequential-advance counter; every non-sequential load restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VEC;
      seq_count <= 16'd0;
    end else begin
      case (src)
        SRC_EXC: begin
          pc        <= EXC_VEC;
          seq_count <= 16'd0;
        end
        SRC_ERET: begin
          pc        <= epc;
          seq_count <= 16'd0;
        end
        SRC_BR: begin
          pc        <= br_target;
          seq_count <= 16'd0;
        end
        SRC_PEND: begin
          pc        <= pend_target;
          seq_count <= 16'd0;
        end
        SRC_SEQ: begin
          pc        <= pc_plus;
          seq_count <= sat_inc16(seq_count);
        end
        default: begin
          pc        <= pc;
          seq_count <= seq_count;
        end
      endcase
    end
  end

endmodule
